// File: rtl/mm_result_collector.sv
// mm_result_collector
//   Captures one result matrix (up to MAX_DIM x MAX_DIM signed elements)
//   streamed out of the matrix-multiply engine. It recovers the row and
//   column counts, records an illegal verdict, then plays the matrix back
//   to the host one element per rd_req before re-arming for the next one.
//
//   Optional feature: define MM_RESULT_CHECKSUM_EN to add the `checksum`
//   output (signed sum of every legal element actually stored).
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_data/in_valid/     result stream from the multiplier; in_legal=0
//   in_legal/in_change_row  with in_valid is an illegal verdict,
//   in_busy               change_row marks the last element of a row
//   rd_req                host read request, one element per pulse
//   rd_data/rd_row/rd_col one registered element with its indices
//   rd_valid/rd_last      1-cycle response strobe, last element flag
//   done/illegal          matrix readable / multiply was illegal
//   res_rows/res_cols     recovered dimensions (0 when illegal)
//   overflow              too many elements or first row too long
//   checksum              (MM_RESULT_CHECKSUM_EN only) sum of stored elements
module mm_result_collector #(
  parameter int DW      = 20,
  parameter int MAX_DIM = 4,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int IW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_legal,
  input  logic          in_change_row,
  input  logic          in_busy,
  input  logic          rd_req,
  output logic [DW-1:0] rd_data,
  output logic [IW-1:0] rd_row,
  output logic [IW-1:0] rd_col,
  output logic          rd_valid,
  output logic          rd_last,
  output logic          done,
  output logic          illegal,
  output logic [IW:0]   res_rows,
  output logic [IW:0]   res_cols,
  output logic          overflow
`ifdef MM_RESULT_CHECKSUM_EN
  , output logic [DW+3:0] checksum
`endif
);

  localparam int TW = 2*IW + 2;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [IW+1:0] MAXC_C  = (IW+2)'(MAX_DIM);
  localparam logic [IW:0]   MAXR_C  = (IW+1)'(MAX_DIM);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READY} state_t;

  state_t        state_q, state_d;
  logic          busy_prev_q, busy_prev_d;
  logic [AW:0]   elem_cnt_q, elem_cnt_d;
  logic [IW+1:0] col_cnt_q, col_cnt_d;
  logic          first_row_done_q, first_row_done_d;
  logic [IW:0]   row_cnt_q, row_cnt_d;
  logic [IW:0]   res_rows_q, res_rows_d;
  logic [IW:0]   res_cols_q, res_cols_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] rd_row_cnt_q, rd_row_cnt_d;
  logic [IW-1:0] rd_col_cnt_q, rd_col_cnt_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [IW-1:0] rd_row_q, rd_row_d;
  logic [IW-1:0] rd_col_q, rd_col_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
`ifdef MM_RESULT_CHECKSUM_EN
  logic [DW+3:0] checksum_q, checksum_d;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic          store;
  logic          busy_fall;
  logic          is_last;
  logic [TW-1:0] total;
  logic [TW-1:0] rd_cnt;

  assign busy_fall = busy_prev_q & ~in_busy;
  assign total     = TW'(res_rows_q) * TW'(res_cols_q);
  assign rd_cnt    = TW'(rd_ptr_q) + TW'(1);
  // A zero-size matrix (illegal, or no row ever closed) still ends on the
  // first read so the host can never stall in READY.
  assign is_last   = (rd_cnt >= total);

  always_comb begin
    state_d          = state_q;
    busy_prev_d      = in_busy;
    elem_cnt_d       = elem_cnt_q;
    col_cnt_d        = col_cnt_q;
    first_row_done_d = first_row_done_q;
    row_cnt_d        = row_cnt_q;
    res_rows_d       = res_rows_q;
    res_cols_d       = res_cols_q;
    done_d           = done_q;
    illegal_d        = illegal_q;
    overflow_d       = overflow_q;
    rd_ptr_d         = rd_ptr_q;
    rd_row_cnt_d     = rd_row_cnt_q;
    rd_col_cnt_d     = rd_col_cnt_q;
    rd_data_d        = rd_data_q;
    rd_row_d         = rd_row_q;
    rd_col_d         = rd_col_q;
    rd_valid_d       = 1'b0;
    rd_last_d        = 1'b0;
    store            = 1'b0;
`ifdef MM_RESULT_CHECKSUM_EN
    checksum_d       = checksum_q;
`endif

    case (state_q)
      // Counters are all zero in IDLE, so the first element shares the
      // capture path (including a 1-column first row).
      S_IDLE, S_CAPTURE: begin
        if (in_valid && in_legal) begin
          if (elem_cnt_q < DEPTH_C) begin
            store      = 1'b1;
            elem_cnt_d = elem_cnt_q + 1'b1;
`ifdef MM_RESULT_CHECKSUM_EN
            checksum_d = checksum_q + {{4{in_data[DW-1]}}, in_data};
`endif
          end else begin
            overflow_d = 1'b1;
          end
          if (!first_row_done_q) begin
            if (col_cnt_q >= MAXC_C) overflow_d = 1'b1;
            if (col_cnt_q <= MAXC_C) col_cnt_d = col_cnt_q + 1'b1;
            if (in_change_row) begin
              first_row_done_d = 1'b1;
              res_cols_d = (col_cnt_d > MAXC_C) ? MAXR_C : col_cnt_d[IW:0];
            end
          end
          if (in_change_row && (row_cnt_q < MAXR_C)) row_cnt_d = row_cnt_q + 1'b1;
          if (state_q == S_IDLE) state_d = S_CAPTURE;
        end else if ((state_q == S_IDLE) && in_valid) begin
          illegal_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_READY;
        end
        if ((state_q == S_CAPTURE) && busy_fall) begin
          res_rows_d = row_cnt_d;
          done_d     = 1'b1;
          state_d    = S_READY;
        end
      end

      S_READY: begin
        if (rd_req) begin
          rd_valid_d = 1'b1;
          rd_last_d  = illegal_q | is_last;
          rd_data_d  = illegal_q ? '0 : mem[rd_ptr_q];
          rd_row_d   = rd_row_cnt_q;
          rd_col_d   = rd_col_cnt_q;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          if (({1'b0, rd_col_cnt_q} + 1'b1) == res_cols_q) begin
            rd_col_cnt_d = '0;
            rd_row_cnt_d = rd_row_cnt_q + 1'b1;
          end else begin
            rd_col_cnt_d = rd_col_cnt_q + 1'b1;
          end
          if (illegal_q || is_last) begin
            state_d          = S_IDLE;
            elem_cnt_d       = '0;
            col_cnt_d        = '0;
            first_row_done_d = 1'b0;
            row_cnt_d        = '0;
            res_rows_d       = '0;
            res_cols_d       = '0;
            done_d           = 1'b0;
            illegal_d        = 1'b0;
            overflow_d       = 1'b0;
            rd_ptr_d         = '0;
            rd_row_cnt_d     = '0;
            rd_col_cnt_d     = '0;
`ifdef MM_RESULT_CHECKSUM_EN
            checksum_d       = '0;
`endif
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      busy_prev_q      <= 1'b0;
      elem_cnt_q       <= '0;
      col_cnt_q        <= '0;
      first_row_done_q <= 1'b0;
      row_cnt_q        <= '0;
      res_rows_q       <= '0;
      res_cols_q       <= '0;
      done_q           <= 1'b0;
      illegal_q        <= 1'b0;
      overflow_q       <= 1'b0;
      rd_ptr_q         <= '0;
      rd_row_cnt_q     <= '0;
      rd_col_cnt_q     <= '0;
      rd_data_q        <= '0;
      rd_row_q         <= '0;
      rd_col_q         <= '0;
      rd_valid_q       <= 1'b0;
      rd_last_q        <= 1'b0;
`ifdef MM_RESULT_CHECKSUM_EN
      checksum_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      busy_prev_q      <= busy_prev_d;
      elem_cnt_q       <= elem_cnt_d;
      col_cnt_q        <= col_cnt_d;
      first_row_done_q <= first_row_done_d;
      row_cnt_q        <= row_cnt_d;
      res_rows_q       <= res_rows_d;
      res_cols_q       <= res_cols_d;
      done_q           <= done_d;
      illegal_q        <= illegal_d;
      overflow_q       <= overflow_d;
      rd_ptr_q         <= rd_ptr_d;
      rd_row_cnt_q     <= rd_row_cnt_d;
      rd_col_cnt_q     <= rd_col_cnt_d;
      rd_data_q        <= rd_data_d;
      rd_row_q         <= rd_row_d;
      rd_col_q         <= rd_col_d;
      rd_valid_q       <= rd_valid_d;
      rd_last_q        <= rd_last_d;
`ifdef MM_RESULT_CHECKSUM_EN
      checksum_q       <= checksum_d;
`endif
    end
  end

  // Buffer contents need no reset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (store) mem[elem_cnt_q[AW-1:0]] <= in_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_row   = rd_row_q;
  assign rd_col   = rd_col_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign res_rows = res_rows_q;
  assign res_cols = res_cols_q;
  assign overflow = overflow_q;
`ifdef MM_RESULT_CHECKSUM_EN
  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mm_result_collector.sv
// Bench for mm_result_collector: directed scenarios plus randomized matrices
// checked against a queue-based reference of the expected matrix.
module tb_mm_result_collector;
  localparam int DW = 20;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_legal, in_change_row, in_busy, rd_req;
  logic [DW-1:0] rd_data;
  logic [IW-1:0] rd_row, rd_col;
  logic          rd_valid, rd_last, done, illegal, overflow;
  logic [IW:0]   res_rows, res_cols;
`ifdef MM_RESULT_CHECKSUM_EN
  logic [DW+3:0] checksum;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  int exp_q[$];
  int exp_rows, exp_cols, exp_sum;
  bit exp_illegal, exp_ovf;

  mm_result_collector dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_legal(in_legal),
    .in_change_row(in_change_row), .in_busy(in_busy),
    .rd_req(rd_req), .rd_data(rd_data), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rd_valid), .rd_last(rd_last), .done(done), .illegal(illegal),
    .res_rows(res_rows), .res_cols(res_cols), .overflow(overflow)
`ifdef MM_RESULT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Builds the expected matrix from a stream: rows close every `cols`
  // elements, only the first 16 are kept, the rest flag overflow.
  task automatic model_legal(input int vals[$], input int cols);
    int n_rows;
    exp_q = {};
    exp_sum = 0;
    for (int i = 0; i < vals.size() && i < 16; i++) begin
      exp_q.push_back(vals[i]);
      exp_sum += vals[i];
    end
    n_rows = vals.size() / cols;
    exp_rows = (n_rows > 4) ? 4 : n_rows;
    exp_cols = cols;
    exp_illegal = 0;
    exp_ovf = (vals.size() > 16);
  endtask

  task automatic stream(input int vals[$], input int cols, input bit coincide, input bit gaps);
    @(negedge clk);
    in_busy = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < vals.size(); i++) begin
      int g;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_legal = 1'($urandom);
        in_change_row = 1'($urandom);
        in_data = DW'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_legal = 1'b1;
      in_data = DW'(vals[i]);
      in_change_row = ((i + 1) % cols == 0);
      if (coincide && i == vals.size() - 1) in_busy = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_change_row = 1'b0;
    if (!coincide) begin
      in_busy = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_ready(input string tag);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL %s done: got %b want 1", tag, done); end
    checks++;
    if (illegal !== exp_illegal) begin failures++; $display("FAIL %s illegal: got %b want %b", tag, illegal, exp_illegal); end
    checks++;
    if (res_rows !== (IW+1)'(exp_rows)) begin failures++; $display("FAIL %s res_rows: got %0d want %0d", tag, res_rows, exp_rows); end
    checks++;
    if (res_cols !== (IW+1)'(exp_cols)) begin failures++; $display("FAIL %s res_cols: got %0d want %0d", tag, res_cols, exp_cols); end
    checks++;
    if (overflow !== exp_ovf) begin failures++; $display("FAIL %s overflow: got %b want %b", tag, overflow, exp_ovf); end
`ifdef MM_RESULT_CHECKSUM_EN
    checks++;
    if (checksum !== (DW+4)'(exp_illegal ? 0 : exp_sum)) begin
      failures++; $display("FAIL %s checksum: got %0d want %0d", tag, $signed(checksum), exp_illegal ? 0 : exp_sum);
    end
`endif
  endtask

  // Reads the whole matrix back and compares each response with the model.
  task automatic run_readback(input string tag, input bit b2b);
    int n;
    n = exp_illegal ? 1 : exp_q.size();
    for (int i = 0; i < n; i++) begin
      int e_row, e_col, e_dat;
      if (!b2b) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          rd_req = 1'b0;
          @(negedge clk);
          checks++;
          if (rd_valid !== 1'b0) begin failures++; $display("FAIL %s idle rd_valid: got %b want 0", tag, rd_valid); end
        end
      end
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      e_row = exp_illegal ? 0 : i / exp_cols;
      e_col = exp_illegal ? 0 : i % exp_cols;
      e_dat = exp_illegal ? 0 : exp_q[i];
      checks++;
      if (rd_valid !== 1'b1) begin failures++; $display("FAIL %s rd_valid[%0d]: got %b want 1", tag, i, rd_valid); end
      checks++;
      if (rd_data !== DW'(e_dat)) begin failures++; $display("FAIL %s rd_data[%0d]: got %0d want %0d", tag, i, $signed(rd_data), e_dat); end
      checks++;
      if (rd_row !== IW'(e_row) || rd_col !== IW'(e_col)) begin
        failures++; $display("FAIL %s rd_idx[%0d]: got (%0d,%0d) want (%0d,%0d)", tag, i, rd_row, rd_col, e_row, e_col);
      end
      checks++;
      if (rd_last !== (i == n - 1)) begin failures++; $display("FAIL %s rd_last[%0d]: got %b want %b", tag, i, rd_last, (i == n - 1)); end
    end
    // a request right after the last element must be ignored and state cleared
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL %s post-last rd_valid: got %b want 0", tag, rd_valid); end
    checks++;
    if (done !== 1'b0 || illegal !== 1'b0 || overflow !== 1'b0 || res_rows !== '0 || res_cols !== '0) begin
      failures++;
      $display("FAIL %s rearm: got done=%b ill=%b ovf=%b rows=%0d cols=%0d want all 0", tag, done, illegal, overflow, res_rows, res_cols);
    end
`ifdef MM_RESULT_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin failures++; $display("FAIL %s rearm checksum: got %0d want 0", tag, checksum); end
`endif
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (rd_data !== '0 || rd_row !== '0 || rd_col !== '0 || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
        done !== 1'b0 || illegal !== 1'b0 || res_rows !== '0 || res_cols !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL %s outputs: got data=%0d row=%0d col=%0d v=%b l=%b done=%b ill=%b rows=%0d cols=%0d ovf=%b want all 0",
               tag, rd_data, rd_row, rd_col, rd_valid, rd_last, done, illegal, res_rows, res_cols, overflow);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL idle_rd_req rd_valid: got %b want 0", rd_valid); end
  endtask

  task automatic test_legal_2x2();
    int v[$] = '{58, 64, 139, 154};
    model_legal(v, 2);
    stream(v, 2, 1'b0, 1'b0);
    check_ready("legal2x2");
`ifdef MM_RESULT_CHECKSUM_EN
    checks++;
    if (checksum !== 24'd415) begin failures++; $display("FAIL legal2x2 checksum415: got %0d want 415", checksum); end
`endif
    run_readback("legal2x2", 1'b0);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    in_valid = 1'b1;
    in_legal = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_legal = 1'b1;
    exp_q = {};
    exp_rows = 0; exp_cols = 0; exp_sum = 0;
    exp_illegal = 1; exp_ovf = 0;
    check_ready("illegal");
    run_readback("illegal", 1'b1);
  endtask

  task automatic test_negative_1x3();
    int v[$] = '{-5, 200, -1000};
    model_legal(v, 3);
    stream(v, 3, 1'b1, 1'b1);
    check_ready("neg1x3");
    run_readback("neg1x3", 1'b0);
  endtask

  task automatic test_back_to_back();
    int v[$];
    for (int i = 1; i <= 16; i++) v.push_back(i);
    model_legal(v, 4);
    stream(v, 4, 1'b0, 1'b0);
    check_ready("b2b4x4");
    run_readback("b2b4x4", 1'b1);
  endtask

  task automatic test_overflow();
    int v[$];
    for (int i = 0; i < 17; i++) v.push_back(int'($urandom_range(0, 1000)) - 500);
    model_legal(v, 4);
    stream(v, 4, 1'b0, 1'b1);
    check_ready("overflow17");
    run_readback("overflow17", 1'b1);
  endtask

  task automatic test_reset_mid_capture();
    int v[$] = '{7, -8, 9, 10};
    @(negedge clk);
    in_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_legal = 1'b1; in_data = DW'(v[i] * 3); in_change_row = (i == 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_change_row = 1'b0;
    in_busy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    model_legal(v, 2);
    stream(v, 2, 1'b0, 1'b1);
    check_ready("after_reset");
    run_readback("after_reset", 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int r, c;
      int v[$];
      r = $urandom_range(1, 4);
      c = $urandom_range(1, 4);
      v = {};
      for (int i = 0; i < r * c; i++) v.push_back(int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1)));
      model_legal(v, c);
      stream(v, c, 1'($urandom), 1'b1);
      check_ready($sformatf("rand%0d", t));
      run_readback($sformatf("rand%0d", t), 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; in_legal = 1'b0; in_change_row = 1'b0;
    in_busy = 1'b0; rd_req = 1'b0;
    test_reset();
    test_legal_2x2();
    test_illegal();
    test_negative_1x3();
    test_back_to_back();
    test_overflow();
    test_reset_mid_capture();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
